// File: rtl/game_pkg.sv
// Shared types and widths for the penalty shootout game.
// Holds the screen state, game mode, control FSM state and bus widths.
package game_pkg;

    localparam int unsigned ROUND_W = 5;
    localparam int unsigned SCORE_W = 8;

    typedef enum logic [2:0] {
        START,
        KEEPER,
        SHOOTER,
        WINNER,
        LOOSER
    } game_state_t;

    typedef enum logic {
        SOLO,
        MULTI
    } game_mode_t;

    typedef enum logic [2:0] {
        IDLE,
        KICK,
        HOLD,
        DECIDE,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/control_if.sv
// Control bus from the match sequencer to the screen selector and drawing blocks.
// Fields: game_state, round_counter, score = {player, opp}, is_scored, game_mode.
interface control_if;

    game_pkg::game_state_t             game_state;
    logic [game_pkg::ROUND_W-1:0]      round_counter;
    logic [game_pkg::SCORE_W-1:0]      score;
    logic                              is_scored;
    game_pkg::game_mode_t              game_mode;

    modport out (
        output game_state,
        output round_counter,
        output score,
        output is_scored,
        output game_mode
    );

    modport in (
        input game_state,
        input round_counter,
        input score,
        input is_scored,
        input game_mode
    );

endinterface

// File: rtl/frame_timer.sv
// Frame tick counter with synchronous clear and a limit compare.
// Ports: clk, rst (sync, active-high), clear, frame_tick, limit,
//        hit_c (combinational: the current tick is the limit-th since clear).
module frame_timer #(
    parameter int unsigned CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             frame_tick,
    input  logic [CNT_W-1:0] limit,
    output logic             hit_c
);

    logic [CNT_W-1:0] count_q;

    // Frame counter; the owner clears it on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (frame_tick) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Fires on the tick that brings the count up to the limit.
    assign hit_c = frame_tick && (count_q == (limit - CNT_W'(1)));

endmodule

// File: rtl/penalty_match_ctrl.sv
// Penalty shootout match sequencer.
// Alternates player/opponent kicks, holds each kick result on screen, applies
// kick timeouts and early-termination / sudden-death rules, drives end screens.
// Ports: clk, rst (sync, active-high), frame_tick, btn_start, mode_sel,
//        shot_done, shot_scored, out_control (registered control bus).
module penalty_match_ctrl
    import game_pkg::*;
#(
    parameter int unsigned REG_KICKS      = 10,
    parameter int unsigned MAX_KICKS      = 20,
    parameter int unsigned RESULT_FRAMES  = 120,
    parameter int unsigned TIMEOUT_FRAMES = 600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_start,
    input  game_mode_t mode_sel,
    input  logic       shot_done,
    input  logic       shot_scored,
    control_if.out     out_control
);

    localparam int unsigned HALF_KICKS = REG_KICKS / 2;
    localparam int unsigned TIMER_MAX  = (TIMEOUT_FRAMES > RESULT_FRAMES) ? TIMEOUT_FRAMES
                                                                          : RESULT_FRAMES;
    localparam int unsigned TIMER_W    = $clog2(TIMER_MAX + 1);
    localparam int unsigned NIB_W      = SCORE_W / 2;
    localparam int unsigned CALC_W     = 6;

    // Reject parameter sets that break the kick alternation or overflow a nibble.
    if (((REG_KICKS % 2) != 0) || ((MAX_KICKS % 2) != 0) || (MAX_KICKS < REG_KICKS) ||
        ((MAX_KICKS / 2) > 15) || (MAX_KICKS >= (1 << ROUND_W)) ||
        (RESULT_FRAMES == 0) || (TIMEOUT_FRAMES == 0)) begin : g_param_check
        $fatal(1, "penalty_match_ctrl: illegal parameter set");
    end

    ctrl_state_t        state_q, state_d;
    game_state_t        gs_q, gs_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [NIB_W-1:0]   p_q, p_d;
    logic [NIB_W-1:0]   c_q, c_d;
    logic               is_q, is_d;
    game_mode_t         mode_q, mode_d;

    logic               timer_clr_c;
    logic               timer_hit_c;
    logic [TIMER_W-1:0] timer_limit_c;

    logic [CALC_W-1:0]  p_ext, c_ext, pt_c, ct_c;
    logic               reg_phase_c, win_c, lose_c;

    // One timer serves both the kick timeout and the result hold.
    assign timer_limit_c = (state_q == HOLD) ? TIMER_W'(RESULT_FRAMES) : TIMER_W'(TIMEOUT_FRAMES);
    assign timer_clr_c   = (state_d != state_q) || ((state_q != KICK) && (state_q != HOLD));

    frame_timer #(
        .CNT_W (TIMER_W)
    ) u_frame_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (timer_clr_c),
        .frame_tick (frame_tick),
        .limit      (timer_limit_c),
        .hit_c      (timer_hit_c)
    );

    // Kicks taken so far per side: player shoots on even rounds, so it leads by ceil.
    assign p_ext       = CALC_W'(p_q);
    assign c_ext       = CALC_W'(c_q);
    assign pt_c        = CALC_W'(({1'b0, round_q} + CALC_W'(1)) >> 1);
    assign ct_c        = CALC_W'({1'b0, round_q} >> 1);
    assign reg_phase_c = (round_q <= ROUND_W'(REG_KICKS));

    // A side wins early once the other cannot catch up with its remaining kicks.
    always_comb begin
        win_c  = 1'b0;
        lose_c = 1'b0;
        if (reg_phase_c) begin
            win_c  = p_ext > (c_ext + (CALC_W'(HALF_KICKS) - ct_c));
            lose_c = c_ext > (p_ext + (CALC_W'(HALF_KICKS) - pt_c));
        end else if (!round_q[0]) begin
            win_c  = p_ext > c_ext;
            lose_c = c_ext > p_ext;
        end
        if ((round_q == ROUND_W'(MAX_KICKS)) && (p_q == c_q)) begin
            lose_c = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gs_q    <= START;
            round_q <= '0;
            p_q     <= '0;
            c_q     <= '0;
            is_q    <= 1'b0;
            mode_q  <= MULTI;
        end else begin
            state_q <= state_d;
            gs_q    <= gs_d;
            round_q <= round_d;
            p_q     <= p_d;
            c_q     <= c_d;
            is_q    <= is_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        gs_d    = gs_q;
        round_d = round_q;
        p_d     = p_q;
        c_d     = c_q;
        is_d    = is_q;
        mode_d  = mode_q;

        case (state_q)
            IDLE: begin
                if (btn_start) begin
                    mode_d  = mode_sel;
                    round_d = '0;
                    p_d     = '0;
                    c_d     = '0;
                    is_d    = 1'b0;
                    gs_d    = SHOOTER;
                    state_d = KICK;
                end
            end
            KICK: begin
                // A resolved shot takes priority over a simultaneous timeout.
                if (shot_done) begin
                    is_d = shot_scored;
                    if (shot_scored) begin
                        if (round_q[0]) begin
                            c_d = c_q + NIB_W'(1);
                        end else begin
                            p_d = p_q + NIB_W'(1);
                        end
                    end
                    state_d = HOLD;
                end else if (timer_hit_c) begin
                    is_d    = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (timer_hit_c) begin
                    is_d    = 1'b0;
                    round_d = (round_q == ROUND_W'(MAX_KICKS)) ? round_q : round_q + ROUND_W'(1);
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                if (win_c) begin
                    gs_d    = WINNER;
                    state_d = DONE;
                end else if (lose_c) begin
                    gs_d    = LOOSER;
                    state_d = DONE;
                end else begin
                    gs_d    = round_q[0] ? KEEPER : SHOOTER;
                    state_d = KICK;
                end
            end
            DONE: begin
                if (btn_start) begin
                    gs_d    = START;
                    round_d = '0;
                    p_d     = '0;
                    c_d     = '0;
                    is_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_control.game_state    = gs_q;
    assign out_control.round_counter = round_q;
    assign out_control.score         = {p_q, c_q};
    assign out_control.is_scored     = is_q;
    assign out_control.game_mode     = mode_q;

endmodule

// File: tb/tb_penalty_match_ctrl.sv
// Scoreboard bench for penalty_match_ctrl: stimulus queues the expected bus
// snapshot for every output change; the monitor pops one per observed change.
module tb_penalty_match_ctrl;
    import game_pkg::*;

    localparam int unsigned RES = 120;
    localparam int unsigned TO  = 600;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       btn_start;
    game_mode_t mode_sel;
    logic       shot_done;
    logic       shot_scored;

    control_if ctrl ();

    penalty_match_ctrl #(
        .REG_KICKS      (10),
        .MAX_KICKS      (14),
        .RESULT_FRAMES  (RES),
        .TIMEOUT_FRAMES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .btn_start   (btn_start),
        .mode_sel    (mode_sel),
        .shot_done   (shot_done),
        .shot_scored (shot_scored),
        .out_control (ctrl)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        game_state_t        st;
        logic [ROUND_W-1:0] rnd;
        logic [SCORE_W-1:0] sc;
        logic               is;
        game_mode_t         md;
    } snap_t;

    snap_t q[$];
    snap_t exp_cur;
    int    checks = 0;
    int    errors = 0;

    // Queue a snapshot only when it differs from the last one expected.
    function automatic void expect_snap(game_state_t st, logic [ROUND_W-1:0] rnd,
                                        logic [SCORE_W-1:0] sc, logic is, game_mode_t md);
        snap_t s;
        s = '{st, rnd, sc, is, md};
        if (s != exp_cur) begin
            q.push_back(s);
            exp_cur = s;
        end
    endfunction

    task automatic cyc_pulse(input logic tk, input logic st, input logic sh, input logic scd);
        frame_tick  = tk;
        btn_start   = st;
        shot_done   = sh;
        shot_scored = scd;
        @(posedge clk);
        #1;
        frame_tick  = 1'b0;
        btn_start   = 1'b0;
        shot_done   = 1'b0;
        shot_scored = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cyc_pulse(1'b1, 1'b0, 1'b0, 1'b0);
            cyc_pulse(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        expect_snap(START, 5'd0, 8'h00, 1'b0, MULTI);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic start_game(input game_mode_t m);
        mode_sel = m;
        expect_snap(SHOOTER, 5'd0, 8'h00, 1'b0, m);
        cyc_pulse(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // One kick resolved by shot_done, then the full result hold; next_st is hand-given.
    task automatic kick(input logic scored, input game_state_t next_st);
        logic [ROUND_W-1:0] r;
        logic [SCORE_W-1:0] s;
        game_state_t        cur;
        game_mode_t         md;
        r   = exp_cur.rnd;
        s   = exp_cur.sc;
        cur = exp_cur.st;
        md  = exp_cur.md;
        if (scored) begin
            s = r[0] ? (s + 8'h01) : (s + 8'h10);
            expect_snap(cur, r, s, 1'b1, md);
        end
        cyc_pulse(1'b0, 1'b0, 1'b1, scored);
        expect_snap(cur, r + 5'd1, s, 1'b0, md);
        expect_snap(next_st, r + 5'd1, s, 1'b0, md);
        ticks(RES);
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected output changes never seen, required 0", name, q.size());
            q.delete();
        end
    endtask

    // Monitor: every change of the control bus is compared against the queue head.
    snap_t mon_cur, mon_prev, mon_exp;
    bit    mon_first = 1'b1;
    int    mon_idx   = 0;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            mon_cur = '{ctrl.game_state, ctrl.round_counter, ctrl.score,
                        ctrl.is_scored, ctrl.game_mode};
            if (mon_first || (mon_cur !== mon_prev)) begin
                mon_first = 1'b0;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change#%0d: got st=%0d rnd=%0d sc=%h is=%b md=%0d, required no change",
                             mon_idx, mon_cur.st, mon_cur.rnd, mon_cur.sc, mon_cur.is, mon_cur.md);
                end else begin
                    mon_exp = q.pop_front();
                    if (mon_cur !== mon_exp) begin
                        errors++;
                        $display("FAIL snapshot#%0d: got st=%0d rnd=%0d sc=%h is=%b md=%0d, required st=%0d rnd=%0d sc=%h is=%b md=%0d",
                                 mon_idx, mon_cur.st, mon_cur.rnd, mon_cur.sc, mon_cur.is, mon_cur.md,
                                 mon_exp.st, mon_exp.rnd, mon_exp.sc, mon_exp.is, mon_exp.md);
                    end
                end
                mon_idx++;
            end
            mon_prev = mon_cur;
        end
    end

    initial begin
        rst         = 1'b1;
        frame_tick  = 1'b0;
        btn_start   = 1'b0;
        shot_done   = 1'b0;
        shot_scored = 1'b0;
        mode_sel    = MULTI;
        exp_cur     = '{START, 5'd0, 8'h00, 1'b0, MULTI};
        q.push_back(exp_cur);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        drain("reset_state");

        // Player scores every kick, opponent misses: early win after six kicks.
        start_game(SOLO);
        kick(1'b1, KEEPER);
        kick(1'b0, SHOOTER);
        kick(1'b1, KEEPER);
        kick(1'b0, SHOOTER);
        kick(1'b1, KEEPER);
        kick(1'b0, WINNER);
        cyc_pulse(1'b0, 1'b0, 1'b1, 1'b1);
        ticks(3);
        expect_snap(START, 5'd0, 8'h00, 1'b0, SOLO);
        cyc_pulse(1'b0, 1'b1, 1'b0, 1'b0);
        drain("early_win_6_kicks");

        // 5-5 through regulation, then sudden death 6-5.
        start_game(MULTI);
        cyc_pulse(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            kick(1'b1, (i % 2 == 0) ? KEEPER : SHOOTER);
        end
        kick(1'b1, KEEPER);
        kick(1'b0, WINNER);
        drain("sudden_death_win");

        // Kick timeout counts as a miss.
        do_reset();
        start_game(MULTI);
        ticks(TO);
        expect_snap(SHOOTER, 5'd1, 8'h00, 1'b0, MULTI);
        expect_snap(KEEPER, 5'd1, 8'h00, 1'b0, MULTI);
        ticks(RES);
        drain("kick_timeout");

        // Scored shot on the timeout tick wins; shot and start during hold are ignored.
        do_reset();
        start_game(MULTI);
        ticks(TO - 1);
        expect_snap(SHOOTER, 5'd0, 8'h10, 1'b1, MULTI);
        cyc_pulse(1'b1, 1'b0, 1'b1, 1'b1);
        ticks(10);
        cyc_pulse(1'b0, 1'b0, 1'b1, 1'b1);
        cyc_pulse(1'b0, 1'b1, 1'b0, 1'b0);
        expect_snap(SHOOTER, 5'd1, 8'h10, 1'b0, MULTI);
        expect_snap(KEEPER, 5'd1, 8'h10, 1'b0, MULTI);
        ticks(RES - 10);
        drain("shot_beats_timeout");

        // Reset in the middle of a hold with score 2-1.
        do_reset();
        start_game(MULTI);
        kick(1'b1, KEEPER);
        kick(1'b1, SHOOTER);
        expect_snap(SHOOTER, 5'd2, 8'h21, 1'b1, MULTI);
        cyc_pulse(1'b0, 1'b0, 1'b1, 1'b1);
        ticks(30);
        do_reset();
        drain("reset_mid_hold");

        // Every kick missed: tie at the 14-kick limit loses; mode stays as latched.
        start_game(SOLO);
        mode_sel = MULTI;
        for (int i = 0; i < 13; i++) begin
            kick(1'b0, (i % 2 == 0) ? KEEPER : SHOOTER);
        end
        kick(1'b0, LOOSER);
        drain("max_kicks_tie_loses");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
